// File: rtl/alu_cmd_pkg.sv
// Shared opcodes, widths, FSM states and response payload for the ALU command driver.
package alu_cmd_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned RESULT_W = 8;
    localparam int unsigned OP_W     = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_NEGA = 3'd1;
    localparam logic [OP_W-1:0] OP_NEGB = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd4;
    localparam logic [OP_W-1:0] OP_AND  = 3'd5;
    localparam logic [OP_W-1:0] OP_OR   = 3'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // One response FIFO entry: opcode that produced it plus the sampled ALU byte.
    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [RESULT_W-1:0] data;
    } rsp_entry_t;

    // Opcode k selects ALU function bit (7-k).
    function automatic logic [RESULT_W-1:0] op_to_sel(input logic [OP_W-1:0] op);
        return RESULT_W'(8'b1000_0000 >> op);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO; power-of-2 depth, wrapping pointers, separate occupancy count.
module resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;
    // Head reads as zero when empty so stale storage never leaks out.
    assign o_data_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the one-hot-opcode ALU: drives operands/select for a settle window,
// then captures the result into a response FIFO. One operation in flight at a time.
module alu_cmd_driver
    import alu_cmd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [NIBBLE_W-1:0] cmd_a,
    input  logic [NIBBLE_W-1:0] cmd_b,
    input  logic                cmd_chain,
    output logic [RESULT_W-1:0] alu_operands,
    output logic [RESULT_W-1:0] alu_sel,
    input  logic [RESULT_W-1:0] alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_data,
    output logic [OP_W-1:0]     rsp_op,
    output logic                busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RESULT_W-1:0] r_operands;
    logic [RESULT_W-1:0] w_operands_nxt;
    logic [RESULT_W-1:0] r_sel;
    logic [RESULT_W-1:0] w_sel_nxt;
    logic [OP_W-1:0]     r_op;
    logic [OP_W-1:0]     w_op_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NIBBLE_W-1:0] r_chain;
    logic [NIBBLE_W-1:0] w_chain_nxt;
    logic                w_accept;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [FCNT_W-1:0]   w_count;
    rsp_entry_t          w_push_entry;
    rsp_entry_t          w_head;

    assign cmd_ready         = (r_state == ST_IDLE) && (w_count < FCNT_W'(FIFO_DEPTH)) && !rst;
    assign w_accept          = cmd_valid && cmd_ready;
    assign w_push_entry.op   = r_op;
    assign w_push_entry.data = alu_result;

    assign alu_operands = r_operands;
    assign alu_sel      = r_sel;
    assign busy         = (r_state == ST_DRIVE);
    assign rsp_valid    = !w_empty;
    assign rsp_data     = w_head.data;
    assign rsp_op       = w_head.op;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update: launch on accept, sample the ALU when the settle count expires.
    always_comb begin
        w_state_nxt    = r_state;
        w_operands_nxt = r_operands;
        w_sel_nxt      = r_sel;
        w_op_nxt       = r_op;
        w_cnt_nxt      = r_cnt;
        w_chain_nxt    = r_chain;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_operands_nxt = {(cmd_chain ? r_chain : cmd_a), cmd_b};
                    w_sel_nxt      = op_to_sel(cmd_op);
                    w_op_nxt       = cmd_op;
                    w_cnt_nxt      = CNT_W'(SETTLE_CYCLES - 1);
                    w_state_nxt    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    w_push      = !w_full;
                    w_chain_nxt = alu_result[RESULT_W-1:NIBBLE_W];
                    w_sel_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; reset abandons any in-flight operation and clears the chain history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operands <= '0;
            r_sel      <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_chain    <= '0;
        end else begin
            r_operands <= w_operands_nxt;
            r_sel      <= w_sel_nxt;
            r_op       <= w_op_nxt;
            r_cnt      <= w_cnt_nxt;
            r_chain    <= w_chain_nxt;
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_resp_fifo (
        .clk       (clk),
        .i_rst     (rst),
        .i_push    (w_push),
        .i_data    (w_push_entry),
        .i_pop     (rsp_ready),
        .o_data_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench for alu_cmd_driver with a behavioural one-hot ALU and a response scoreboard.
module tb_alu_cmd_driver;
    import alu_cmd_pkg::*;

    logic       clk;
    logic       rst;

    // DUT with SETTLE_CYCLES=1
    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic [7:0] alu_operands, alu_sel, alu_result;
    logic       rsp_valid, rsp_ready, busy;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;

    // DUT with SETTLE_CYCLES=3
    logic       c3_valid, c3_ready, c3_chain;
    logic [2:0] c3_op;
    logic [3:0] c3_a, c3_b;
    logic [7:0] c3_operands, c3_sel, c3_result;
    logic       c3_rsp_valid, c3_rsp_ready, c3_busy;
    logic [7:0] c3_rsp_data;
    logic [2:0] c3_rsp_op;

    int          total;
    int          bad;
    logic [3:0]  exp_chain;
    logic [10:0] sb[$];

    // Behavioural ALU: nibble ops return {result,4'h0}, MUL returns the full byte, no select gives 0.
    function automatic logic [7:0] alu_stub(input logic [7:0] opnd, input logic [7:0] sel);
        logic [3:0] a;
        logic [3:0] b;
        a = opnd[7:4];
        b = opnd[3:0];
        case (sel)
            8'h80:   return {4'(a + b), 4'h0};
            8'h40:   return {4'(-a), 4'h0};
            8'h20:   return {4'(-b), 4'h0};
            8'h10:   return {4'(a - b), 4'h0};
            8'h08:   return 8'(a) * 8'(b);
            8'h04:   return {(a & b), 4'h0};
            8'h02:   return {(a | b), 4'h0};
            8'h01:   return {(a ^ b), 4'h0};
            default: return 8'h00;
        endcase
    endfunction

    // Reference result for an opcode and effective operands.
    function automatic logic [7:0] exp_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = 4'd0 - a;
            3'd2:    r = 4'd0 - b;
            3'd3:    r = a - b;
            3'd4:    return {4'd0, a} * {4'd0, b};
            3'd5:    r = a & b;
            3'd6:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r, 4'h0};
    endfunction

    assign alu_result = alu_stub(alu_operands, alu_sel);
    assign c3_result  = alu_stub(c3_operands, c3_sel);

    alu_cmd_driver #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_operands(alu_operands), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .busy(busy)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(3), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
        .cmd_a(c3_a), .cmd_b(c3_b), .cmd_chain(c3_chain),
        .alu_operands(c3_operands), .alu_sel(c3_sel), .alu_result(c3_result),
        .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
        .rsp_op(c3_rsp_op), .busy(c3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Offer a command on DUT1, record its expected response, check the drive cycle after accept.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain, input string tag);
        int         n = 0;
        logic [3:0] a_eff;
        logic [7:0] res;
        logic [7:0] onehot;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acc_to"}, 8'(n < 20), 8'd1);
        a_eff     = chain ? exp_chain : a;
        res       = exp_res(op, a_eff, b);
        exp_chain = res[7:4];
        sb.push_back({op, res});
        @(negedge clk);
        cmd_valid = 1'b0;
        onehot    = 8'h80;
        onehot    = onehot >> op;
        chk({tag, "_sel"}, alu_sel, onehot);
        chk({tag, "_opnd"}, alu_operands, {a_eff, b});
        chk({tag, "_busy"}, 8'(busy), 8'd1);
    endtask

    // Wait for a DUT1 response, compare it with the scoreboard head, then pop it.
    task automatic pop_check(input string tag);
        int          n = 0;
        logic [10:0] e;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_to"}, 8'(n < 20), 8'd1);
        chk({tag, "_sb_has"}, 8'(sb.size() != 0), 8'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, rsp_data, e[7:0]);
            chk({tag, "_op"}, 8'(rsp_op), 8'(e[10:8]));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic [3:0]  a5;
        logic [7:0]  r5;
        total = 0;
        bad   = 0;
        exp_chain = 4'h0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_chain = 1'b0; rsp_ready = 1'b0;
        c3_valid = 1'b0; c3_op = 3'd0; c3_a = 4'd0; c3_b = 4'd0; c3_chain = 1'b0; c3_rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
        chk("rst_sel", alu_sel, 8'h00);
        chk("rst_opnd", alu_operands, 8'h00);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_op", 8'(rsp_op), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 8'(cmd_ready), 8'd1);

        // Single ADD: select for one cycle, response one cycle after the accept edge
        send(OP_ADD, 4'd3, 4'd5, 1'b0, "add");
        chk("add_ready_drive", 8'(cmd_ready), 8'd0);
        chk("add_valid_drive", 8'(rsp_valid), 8'd0);
        @(negedge clk);
        chk("add_sel_off", alu_sel, 8'h00);
        chk("add_busy_off", 8'(busy), 8'd0);
        chk("add_opnd_hold", alu_operands, 8'h35);
        chk("add_valid_up", 8'(rsp_valid), 8'd1);
        chk("add_ready_back", 8'(cmd_ready), 8'd1);
        pop_check("add");
        chk("add_drained", 8'(rsp_valid), 8'd0);

        // Back-to-back MUL, SUB, NEGA queued then drained in order
        send(OP_MUL, 4'd7, 4'd6, 1'b0, "mul");
        send(OP_SUB, 4'd5, 4'd3, 1'b0, "sub");
        send(OP_NEGA, 4'd1, 4'd0, 1'b0, "nega");
        pop_check("mul");
        pop_check("sub");
        pop_check("nega");

        // Chain: second ADD takes the upper nibble of the first result as A
        send(OP_ADD, 4'd3, 4'd5, 1'b0, "ch0");
        send(OP_ADD, 4'hF, 4'd1, 1'b1, "ch1");
        pop_check("ch0");
        pop_check("ch1");

        // FIFO full: four accepted, fifth stalls until one pop
        for (int i = 0; i < 4; i++) begin
            send(OP_XOR, 4'(i), 4'hA, 1'b0, "xor");
        end
        a5 = 4'd4;
        cmd_op = OP_XOR; cmd_a = a5; cmd_b = 4'hA; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready", 8'(cmd_ready), 8'd0);
            chk("full_busy", 8'(busy), 8'd0);
        end
        pop_check("full_pop");
        chk("full_ready_again", 8'(cmd_ready), 8'd1);
        r5 = exp_res(OP_XOR, a5, 4'hA);
        exp_chain = r5[7:4];
        sb.push_back({OP_XOR, r5});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("full_5th_busy", 8'(busy), 8'd1);
        for (int i = 0; i < 4; i++) begin
            pop_check("full_drain");
        end
        chk("full_empty", 8'(rsp_valid), 8'd0);

        // Reset during DRIVE: no response, FIFO flushed, chain history cleared
        send(OP_ADD, 4'd2, 4'd2, 1'b0, "pre_rst");
        send(OP_OR, 4'd3, 4'd4, 1'b0, "or_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_sel", alu_sel, 8'h00);
        chk("mrst_valid", 8'(rsp_valid), 8'd0);
        chk("mrst_busy", 8'(busy), 8'd0);
        chk("mrst_ready", 8'(cmd_ready), 8'd0);
        rst = 1'b0;
        sb.delete();
        exp_chain = 4'h0;
        @(negedge clk);
        chk("mrst_valid2", 8'(rsp_valid), 8'd0);
        chk("mrst_ready2", 8'(cmd_ready), 8'd1);
        send(OP_ADD, 4'd9, 4'd2, 1'b1, "chain0");
        pop_check("chain0");
        chk("chain0_empty", 8'(rsp_valid), 8'd0);

        // SETTLE_CYCLES=3: AND held three cycles, commands offered mid-drive are ignored
        c3_op = OP_AND; c3_a = 4'hC; c3_b = 4'hA; c3_chain = 1'b0; c3_valid = 1'b1;
        n = 0;
        while (c3_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s3_acc_to", 8'(n < 20), 8'd1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("s3_busy", 8'(c3_busy), 8'd1);
            chk("s3_sel", c3_sel, 8'h04);
            chk("s3_opnd", c3_operands, 8'hCA);
            chk("s3_no_rsp", 8'(c3_rsp_valid), 8'd0);
            c3_op    = OP_OR;
            c3_valid = (k == 1);
            @(negedge clk);
        end
        chk("s3_busy_off", 8'(c3_busy), 8'd0);
        chk("s3_sel_off", c3_sel, 8'h00);
        chk("s3_valid", 8'(c3_rsp_valid), 8'd1);
        chk("s3_data", c3_rsp_data, exp_res(OP_AND, 4'hC, 4'hA));
        chk("s3_op", 8'(c3_rsp_op), 8'(OP_AND));
        c3_rsp_ready = 1'b1;
        @(negedge clk);
        c3_rsp_ready = 1'b0;
        chk("s3_single_rsp", 8'(c3_rsp_valid), 8'd0);
        chk("s3_idle", 8'(c3_busy), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
